router_fsm: RTL and testbench

Packet-reception controller for the 3-port router. It sits between the input register block and the port synchronizer, decodes the header address, and sequences each packet's header, payload and parity bytes into the addressed output FIFO. It stalls on FIFO-full, waits for a busy destination, and aborts on a destination soft reset. It drives the synchronizer's address-latch and write-enable requests and the register block's load-phase strobes.

---
 rtl/router_fsm_pkg.sv | 18 +
 rtl/router_fsm.sv | 111 +++++++++++
 tb/tb_router_fsm.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_fsm_pkg.sv
// router_fsm_pkg: state encoding and address constants
// shared by router_fsm, synchronizer and register block.
package router_fsm_pkg;

  typedef logic [2:0] state_t;

  localparam state_t DECODE_ADDRESS     = 3'd0;
  localparam state_t LOAD_FIRST_DATA    = 3'd1;
  localparam state_t LOAD_DATA          = 3'd2;
  localparam state_t FIFO_FULL_STATE    = 3'd3;
  localparam state_t LOAD_AFTER_FULL    = 3'd4;
  localparam state_t LOAD_PARITY        = 3'd5;
  localparam state_t CHECK_PARITY_ERROR = 3'd6;
  localparam state_t WAIT_TILL_EMPTY    = 3'd7;

  localparam logic [1:0] ADDR_INVALID = 2'b11;

endpackage

// File: rtl/router_fsm.sv
// router_fsm: packet-reception sequencer for the 3-port
// router; header, payload and parity into the addressed FIFO.
module router_fsm
  import router_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       det_addr,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       full_state,
  output logic       laf_state,
  output logic       rst_int_reg,
  output logic       write_enb_reg,
  output logic       busy
);

  state_t     st, nxt;
  logic [1:0] addr_q;
  logic [3:0] emp;
  logic [3:0] srst;
  logic       sr_hit;
  logic       hdr_ok;

  // Pad to 4 bits so the invalid address reads as 0
  assign emp    = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign srst   = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
  assign sr_hit = srst[addr_q];
  assign hdr_ok = pkt_valid && (data_in != ADDR_INVALID);

  // State and latched destination address
  always_ff @(posedge clk) begin
    if (!rst) begin
      st     <= DECODE_ADDRESS;
      addr_q <= 2'd0;
    end else begin
      st <= nxt;
      if (st == DECODE_ADDRESS && hdr_ok)
        addr_q <= data_in;
    end
  end

  // Next state; an addressed soft reset overrides everything
  always_comb begin
    nxt = st;
    if (sr_hit) begin
      nxt = DECODE_ADDRESS;
    end else begin
      case (st)
        DECODE_ADDRESS:
          if (hdr_ok)
            nxt = emp[data_in] ? LOAD_FIRST_DATA
                               : WAIT_TILL_EMPTY;
        WAIT_TILL_EMPTY:
          if (emp[addr_q])
            nxt = LOAD_FIRST_DATA;
        LOAD_FIRST_DATA:
          nxt = LOAD_DATA;
        LOAD_DATA:
          if (fifo_full)
            nxt = FIFO_FULL_STATE;
          else if (!pkt_valid)
            nxt = LOAD_PARITY;
        FIFO_FULL_STATE:
          if (!fifo_full)
            nxt = LOAD_AFTER_FULL;
        LOAD_AFTER_FULL:
          if (parity_done)
            nxt = DECODE_ADDRESS;
          else if (low_pkt_valid)
            nxt = LOAD_PARITY;
          else
            nxt = LOAD_DATA;
        LOAD_PARITY:
          nxt = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR:
          nxt = fifo_full ? FIFO_FULL_STATE
                          : DECODE_ADDRESS;
        default:
          nxt = DECODE_ADDRESS;
      endcase
    end
  end

  // Moore output decode from the state register only
  always_comb begin
    det_addr      = (st == DECODE_ADDRESS);
    lfd_state     = (st == LOAD_FIRST_DATA);
    ld_state      = (st == LOAD_DATA);
    full_state    = (st == FIFO_FULL_STATE);
    laf_state     = (st == LOAD_AFTER_FULL);
    rst_int_reg   = (st == CHECK_PARITY_ERROR);
    write_enb_reg = (st == LOAD_DATA)
                 || (st == LOAD_PARITY)
                 || (st == LOAD_AFTER_FULL);
    busy          = !((st == DECODE_ADDRESS)
                 || (st == LOAD_DATA));
  end

endmodule

// File: tb/tb_router_fsm.sv
// tb_router_fsm: directed scenarios then random traffic,
// every cycle compared against a behavioural packet model.
module tb_router_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       det_addr, lfd_state, ld_state, full_state;
  logic       laf_state, rst_int_reg, write_enb_reg, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  router_fsm dut (
    .clk          (clk),
    .rst          (rst),
    .pkt_valid    (pkt_valid),
    .data_in      (data_in),
    .fifo_full    (fifo_full),
    .fifo_empty_0 (fifo_empty_0),
    .fifo_empty_1 (fifo_empty_1),
    .fifo_empty_2 (fifo_empty_2),
    .soft_reset_0 (soft_reset_0),
    .soft_reset_1 (soft_reset_1),
    .soft_reset_2 (soft_reset_2),
    .parity_done  (parity_done),
    .low_pkt_valid(low_pkt_valid),
    .det_addr     (det_addr),
    .lfd_state    (lfd_state),
    .ld_state     (ld_state),
    .full_state   (full_state),
    .laf_state    (laf_state),
    .rst_int_reg  (rst_int_reg),
    .write_enb_reg(write_enb_reg),
    .busy         (busy)
  );

  // Behavioural model: packet phase plus destination port
  typedef enum {
    P_IDLE, P_WAIT, P_HDR, P_PAY, P_STALL,
    P_RESUME, P_PAR, P_CHK
  } phase_t;

  phase_t m_ph;
  int     m_port;

  function automatic bit port_empty(int p);
    case (p)
      0: return fifo_empty_0;
      1: return fifo_empty_1;
      2: return fifo_empty_2;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit port_srst(int p);
    case (p)
      0: return soft_reset_0;
      1: return soft_reset_1;
      2: return soft_reset_2;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_tick();
    phase_t n;
    int     np;
    if (!rst) begin
      m_ph   = P_IDLE;
      m_port = 0;
      return;
    end
    n  = m_ph;
    np = m_port;
    if (m_ph == P_IDLE && pkt_valid && data_in != 2'd3)
      np = int'(data_in);
    if (port_srst(m_port)) n = P_IDLE;
    else case (m_ph)
      P_IDLE:
        if (pkt_valid && data_in != 2'd3)
          n = port_empty(int'(data_in)) ? P_HDR : P_WAIT;
      P_WAIT:   if (port_empty(m_port)) n = P_HDR;
      P_HDR:    n = P_PAY;
      P_PAY:
        if (fifo_full)       n = P_STALL;
        else if (!pkt_valid) n = P_PAR;
      P_STALL:  if (!fifo_full) n = P_RESUME;
      P_RESUME:
        if (parity_done)        n = P_IDLE;
        else if (low_pkt_valid) n = P_PAR;
        else                    n = P_PAY;
      P_PAR:    n = P_CHK;
      P_CHK:    n = fifo_full ? P_STALL : P_IDLE;
      default:  n = P_IDLE;
    endcase
    m_ph   = n;
    m_port = np;
  endtask

  // {det,lfd,ld,full,laf,rst_int,wen,busy}
  function automatic logic [7:0] expect_out(phase_t p);
    logic writing;
    writing = (p == P_PAY) || (p == P_PAR) || (p == P_RESUME);
    return {p == P_IDLE, p == P_HDR, p == P_PAY,
            p == P_STALL, p == P_RESUME, p == P_CHK,
            writing, !(p == P_IDLE || p == P_PAY)};
  endfunction

  task automatic chk(string tag, logic [7:0] obs,
                     logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(string tag);
    @(posedge clk);
    model_tick();
    #1;
    chk(tag, {det_addr, lfd_state, ld_state, full_state,
              laf_state, rst_int_reg, write_enb_reg, busy},
        expect_out(m_ph));
  endtask

  initial begin
    rst = 1'b0; pkt_valid = 1'b0; data_in = 2'd0;
    fifo_full = 1'b0;
    fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
    soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
    parity_done = 1'b0; low_pkt_valid = 1'b0;
    m_ph = P_IDLE; m_port = 0;

    // Reset
    step("reset0");
    step("reset1");
    chk1("rst_det", det_addr, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_wen", write_enb_reg, 1'b0);
    rst = 1'b1;

    // Normal packet to port 1, 4 payload bytes
    pkt_valid = 1'b1; data_in = 2'd1;
    step("p1_hdr");
    chk1("p1_lfd", lfd_state, 1'b1);
    for (int i = 0; i < 4; i++) begin
      data_in = 2'($urandom_range(0, 3));
      step("p1_pay");
      chk1("p1_ld", ld_state, 1'b1);
    end
    pkt_valid = 1'b0;
    step("p1_par");
    chk1("p1_par_wen", write_enb_reg, 1'b1);
    chk1("p1_par_busy", busy, 1'b1);
    step("p1_chk");
    chk1("p1_rstint", rst_int_reg, 1'b1);
    step("p1_done");
    chk1("p1_det", det_addr, 1'b1);

    // Busy destination on port 2
    fifo_empty_2 = 1'b0; pkt_valid = 1'b1; data_in = 2'd2;
    step("p2_wait");
    pkt_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step("p2_hold");
      chk1("p2_busy", busy, 1'b1);
      chk1("p2_nowr", write_enb_reg, 1'b0);
    end
    fifo_empty_2 = 1'b1;
    step("p2_lfd");
    chk1("p2_lfd", lfd_state, 1'b1);

    // Full stall then low_pkt_valid recovery
    pkt_valid = 1'b1;
    step("fs_ld");
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("fs_stall");
      chk1("fs_full", full_state, 1'b1);
      chk1("fs_nowr", write_enb_reg, 1'b0);
    end
    fifo_full = 1'b0; pkt_valid = 1'b0; low_pkt_valid = 1'b1;
    step("fs_laf");
    chk1("fs_laf", laf_state, 1'b1);
    step("fs_par");
    chk1("fs_par_wen", write_enb_reg, 1'b1);
    low_pkt_valid = 1'b0;
    step("fs_chk");
    step("fs_idle");

    // Soft reset: port 2 ignored, port 0 aborts
    pkt_valid = 1'b1; data_in = 2'd0;
    step("sr_lfd");
    step("sr_ld");
    soft_reset_2 = 1'b1;
    step("sr_other");
    chk1("sr_other_ld", ld_state, 1'b1);
    soft_reset_2 = 1'b0; soft_reset_0 = 1'b1;
    step("sr_own");
    chk1("sr_own_det", det_addr, 1'b1);
    soft_reset_0 = 1'b0; pkt_valid = 1'b0;
    step("sr_idle");

    // Invalid address
    pkt_valid = 1'b1; data_in = 2'd3;
    step("inv0");
    step("inv1");
    chk1("inv_det", det_addr, 1'b1);
    chk1("inv_busy", busy, 1'b0);

    // Full and end-of-packet together: full wins
    data_in = 2'd1;
    step("fe_lfd");
    step("fe_ld");
    fifo_full = 1'b1; pkt_valid = 1'b0;
    step("fe_full");
    chk1("fe_full", full_state, 1'b1);

    // Reset mid-packet
    fifo_full = 1'b0; pkt_valid = 1'b1;
    step("mr_laf");
    step("mr_ld");
    rst = 1'b0;
    step("mr_rst");
    chk1("mr_det", det_addr, 1'b1);
    chk1("mr_wen", write_enb_reg, 1'b0);
    rst = 1'b1;

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom_range(0, 99) != 0);
      pkt_valid     = ($urandom_range(0, 3) != 0);
      data_in       = 2'($urandom_range(0, 3));
      fifo_full     = ($urandom_range(0, 4) == 0);
      fifo_empty_0  = ($urandom_range(0, 2) != 0);
      fifo_empty_1  = ($urandom_range(0, 2) != 0);
      fifo_empty_2  = ($urandom_range(0, 2) != 0);
      soft_reset_0  = ($urandom_range(0, 29) == 0);
      soft_reset_1  = ($urandom_range(0, 29) == 0);
      soft_reset_2  = ($urandom_range(0, 29) == 0);
      parity_done   = ($urandom_range(0, 3) == 0);
      low_pkt_valid = ($urandom_range(0, 2) == 0);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
